// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and decode: a circular FIFO of {pc, inst}
// entries with valid/ready handshakes on both sides and a core-driven flush.
module inst_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  input  logic [XLEN-1:0]          in_pc_i,
  input  logic [XLEN-1:0]          in_inst_i,
  output logic                     in_ready_o,
  output logic                     out_valid_o,
  output logic [XLEN-1:0]          out_pc_o,
  output logic [XLEN-1:0]          out_inst_o,
  input  logic                     out_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  r_mem_pc   [DEPTH];
  logic [XLEN-1:0]  r_mem_inst [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_nxt;

  // Handshakes qualify only on registered occupancy; flush drops both sides.
  assign w_push = in_valid_i && !r_full  && !flush_i;
  assign w_pop  = out_ready_i && !r_empty && !flush_i;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Control state; reset outranks flush, which outranks push/pop.
  // Pointers are PTR_W bits wide, so DEPTH being a power of two makes them wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Entry storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (w_push && !rst_i) begin
      r_mem_pc[r_wptr]   <= in_pc_i;
      r_mem_inst[r_wptr] <= in_inst_i;
    end
  end

  assign in_ready_o  = !r_full;
  assign out_valid_o = !r_empty;
  assign count_o     = r_count;
  assign out_pc_o    = r_empty ? '0 : r_mem_pc[r_rptr];
  assign out_inst_o  = r_empty ? '0 : r_mem_inst[r_rptr];

endmodule

// File: tb/tb_inst_buffer.sv
// Randomised self-checking bench for inst_buffer against a queue reference model.
module tb_inst_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 32;

  logic                   clk_i = 1'b0;
  logic                   rst_i, flush_i, in_valid_i, out_ready_i;
  logic [XLEN-1:0]        in_pc_i, in_inst_i;
  logic                   in_ready_o, out_valid_o;
  logic [XLEN-1:0]        out_pc_o, out_inst_o;
  logic [$clog2(DEPTH):0] count_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of {pc, inst}, head at index 0.
  logic [2*XLEN-1:0] q[$];

  inst_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_pc_i(in_pc_i), .in_inst_i(in_inst_i),
    .in_ready_o(in_ready_o), .out_valid_o(out_valid_o),
    .out_pc_o(out_pc_o), .out_inst_o(out_inst_o),
    .out_ready_i(out_ready_i), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  // Drive one cycle of stimulus and advance the model by the rules of the buffer.
  task automatic cycle(input logic rst, input logic flush, input logic iv,
                       input logic [XLEN-1:0] pc, input logic [XLEN-1:0] inst,
                       input logic ordy);
    bit push, pop;
    rst_i = rst; flush_i = flush; in_valid_i = iv;
    in_pc_i = pc; in_inst_i = inst; out_ready_i = ordy;
    push = iv && (q.size() < DEPTH) && !flush;
    pop  = ordy && (q.size() > 0) && !flush;
    @(posedge clk_i);
    if (rst || flush) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back({pc, inst});
    end
    @(negedge clk_i);
    rst_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    n_tests++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count_o); end
    n_tests++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid_o); end
    n_tests++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", in_ready_o); end
    n_tests++; if (out_inst_o !== 32'h0) begin n_fail++; $display("FAIL reset_inst got %h exp 0", out_inst_o); end
    n_tests++; if (out_pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", out_pc_o); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 32'(4*i), 32'h000000A0 + 32'(i), 1'b0);
      n_tests++;
      if (out_inst_o !== 32'h000000A0) begin n_fail++; $display("FAIL fill_head got %h exp a0", out_inst_o); end
    end
    n_tests++; if (count_o !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d exp 4", count_o); end
    n_tests++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b exp 0", in_ready_o); end
    cycle(1'b0, 1'b0, 1'b1, 32'h10, 32'h000000B0, 1'b0);
    n_tests++; if (count_o !== 3'd4) begin n_fail++; $display("FAIL full_push_count got %0d exp 4", count_o); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (out_inst_o !== 32'h000000A0 + 32'(i) || out_pc_o !== 32'(4*i) || out_valid_o !== 1'b1) begin
        n_fail++; $display("FAIL drain_%0d got pc %h inst %h v %b exp pc %h inst %h", i,
                           out_pc_o, out_inst_o, out_valid_o, 32'(4*i), 32'h000000A0 + 32'(i));
      end
      cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    end
    n_tests++; if (out_valid_o !== 1'b0 || count_o !== 3'd0) begin n_fail++; $display("FAIL drain_empty got v %b cnt %0d exp 0 0", out_valid_o, count_o); end
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    n_tests++; if (count_o !== 3'd0 || out_inst_o !== 32'h0) begin n_fail++; $display("FAIL pop_empty got cnt %0d inst %h exp 0 0", count_o, out_inst_o); end
  endtask

  task automatic test_wrap();
    cycle(1'b0, 1'b0, 1'b1, 32'h1000, 32'h100, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h1004, 32'h101, 1'b0);
    for (int k = 0; k < 10; k++) begin
      n_tests++;
      if (count_o !== 3'd2 || out_inst_o !== 32'h100 + 32'(k)) begin
        n_fail++; $display("FAIL wrap_%0d got cnt %0d inst %h exp 2 %h", k, count_o, out_inst_o, 32'h100 + 32'(k));
      end
      cycle(1'b0, 1'b0, 1'b1, 32'h1000 + 32'(4*(k+2)), 32'h100 + 32'(k+2), 1'b1);
    end
    for (int k = 10; k < 12; k++) begin
      n_tests++;
      if (out_inst_o !== 32'h100 + 32'(k)) begin n_fail++; $display("FAIL wrap_tail_%0d got %h exp %h", k, out_inst_o, 32'h100 + 32'(k)); end
      cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 32'(i), 32'h300 + 32'(i), 1'b0);
    n_tests++; if (count_o !== 3'd3) begin n_fail++; $display("FAIL flush_pre got %0d exp 3", count_o); end
    cycle(1'b0, 1'b1, 1'b1, 32'h40, 32'h0000DEAD, 1'b1);
    n_tests++;
    if (count_o !== 3'd0 || out_valid_o !== 1'b0 || out_inst_o !== 32'h0) begin
      n_fail++; $display("FAIL flush_post got cnt %0d v %b inst %h exp 0 0 0", count_o, out_valid_o, out_inst_o);
    end
    cycle(1'b0, 1'b1, 1'b1, 32'h44, 32'h0000DEAD, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'h48, 32'h0000DEAD, 1'b0);
    n_tests++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL flush_consec got %0d exp 0", count_o); end
    cycle(1'b0, 1'b0, 1'b1, 32'h50, 32'h55, 1'b0);
    n_tests++;
    if (count_o !== 3'd1 || out_inst_o !== 32'h55) begin n_fail++; $display("FAIL flush_resume got cnt %0d inst %h exp 1 55", count_o, out_inst_o); end
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 1'b0, 1'b1, 32'h60, 32'h600, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h64, 32'h601, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'h68, 32'h00000BAD, 1'b1);
    n_tests++;
    if (count_o !== 3'd0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid got cnt %0d v %b r %b exp 0 0 1", count_o, out_valid_o, in_ready_o);
    end
    cycle(1'b0, 1'b0, 1'b1, 32'h70, 32'h77, 1'b0);
    n_tests++;
    if (out_inst_o !== 32'h77 || out_pc_o !== 32'h70) begin n_fail++; $display("FAIL rst_first got pc %h inst %h exp 70 77", out_pc_o, out_inst_o); end
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_random();
    int errs = 0;
    logic [XLEN-1:0] exp_pc, exp_inst;
    for (int c = 0; c < 10000; c++) begin
      exp_pc   = (q.size() > 0) ? q[0][2*XLEN-1:XLEN] : '0;
      exp_inst = (q.size() > 0) ? q[0][XLEN-1:0]      : '0;
      n_tests++;
      if (count_o !== ($clog2(DEPTH)+1)'(q.size()) || count_o > ($clog2(DEPTH)+1)'(DEPTH) ||
          out_valid_o !== (q.size() != 0) || in_ready_o !== (q.size() != DEPTH) ||
          out_pc_o !== exp_pc || out_inst_o !== exp_inst) begin
        n_fail++; errs++;
        if (errs <= 10)
          $display("FAIL rand_c%0d got cnt %0d v %b r %b pc %h inst %h exp cnt %0d pc %h inst %h",
                   c, count_o, out_valid_o, in_ready_o, out_pc_o, out_inst_o, q.size(), exp_pc, exp_inst);
      end
      cycle(1'b0, ($urandom_range(63) == 0), $urandom_range(1), $urandom, $urandom, $urandom_range(1));
    end
  endtask

  initial begin
    rst_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    in_pc_i = '0; in_inst_i = '0;
    @(negedge clk_i);
    test_reset();
    test_fill_drain();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
